// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// IF-stage sequencer for the RV32I pipeline. Picks at most one next-PC source
// per cycle (trap beats branch/jump), drives redirect_valid/redirect_pc into
// if_stage, defers redirects across ID hazard stalls and raises squash to kill
// the wrong-path instruction held in IF/ID.
//
// Every output is registered. A request sampled at posedge N shows up as
// redirect_valid in cycle N+1.
//
// Parameters
//   RESET_PC       boot PC issued as the first redirect after reset
//   SQUASH_CYCLES  squash duration per redirect, legal 1..3
//
// Ports
//   clk             in   1   clock, all state updates on posedge
//   reset           in   1   synchronous, active-high
//   trap_req        in   1   trap/exception redirect request (highest priority)
//   trap_pc         in   32  trap vector target
//   br_req          in   1   taken branch/jump resolved in EX
//   br_pc           in   32  branch/jump target
//   stall           in   1   ID hazard stall, freezes fetch
//   redirect_valid  out  1   if_stage loads redirect_pc at the next posedge
//   redirect_pc     out  32  redirect target, bits [1:0] forced to zero
//   pc_hold         out  1   if_stage holds PC and IF/ID this cycle
//   squash          out  1   kill the instruction currently in IF/ID
//   misalign        out  1   pulses with redirect_valid if target[1:0] != 0
//
// Optional build macro FETCH_CTRL_PERF_EN adds:
//   perf_redirects  out  32  count of redirect_valid pulses (boot included)
//   perf_squashed   out  32  count of cycles with squash high
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          SQUASH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        trap_req,
   input  logic [31:0] trap_pc,
   input  logic        br_req,
   input  logic [31:0] br_pc,
   input  logic        stall,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        pc_hold,
   output logic        squash,
`ifdef FETCH_CTRL_PERF_EN
   output logic        misalign,
   output logic [31:0] perf_redirects,
   output logic [31:0] perf_squashed
`else
   output logic        misalign
`endif
);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_PEND,
      ST_SQUASH
   } state_t;

   // Counter is loaded with the number of squash cycles still to come after
   // the redirect cycle itself, so 0 means "this is the last squash cycle".
   localparam logic [1:0] SQ_LOAD = 2'(SQUASH_CYCLES - 1);

   state_t      state_reg,          state_next;
   logic [31:0] pend_pc_reg,        pend_pc_next;
   logic [1:0]  sq_cnt_reg,         sq_cnt_next;
   logic        redirect_valid_reg, redirect_valid_next;
   logic [31:0] redirect_pc_reg,    redirect_pc_next;
   logic        pc_hold_reg,        pc_hold_next;
   logic        squash_reg,         squash_next;
   logic        misalign_reg,       misalign_next;

   // Common redirect launch shared by RUN, PEND and SQUASH.
   logic        issue;
   logic [31:0] issue_pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg          <= ST_BOOT;
         pend_pc_reg        <= 32'h0;
         sq_cnt_reg         <= 2'd0;
         redirect_valid_reg <= 1'b0;
         redirect_pc_reg    <= RESET_PC;
         pc_hold_reg        <= 1'b1;
         squash_reg         <= 1'b0;
         misalign_reg       <= 1'b0;
      end else begin
         state_reg          <= state_next;
         pend_pc_reg        <= pend_pc_next;
         sq_cnt_reg         <= sq_cnt_next;
         redirect_valid_reg <= redirect_valid_next;
         redirect_pc_reg    <= redirect_pc_next;
         pc_hold_reg        <= pc_hold_next;
         squash_reg         <= squash_next;
         misalign_reg       <= misalign_next;
      end
   end

   always_comb begin
      state_next          = state_reg;
      pend_pc_next        = pend_pc_reg;
      sq_cnt_next         = sq_cnt_reg;
      redirect_valid_next = 1'b0;
      redirect_pc_next    = redirect_pc_reg;
      pc_hold_next        = stall;
      squash_next         = 1'b0;
      misalign_next       = 1'b0;
      issue               = 1'b0;
      issue_pc            = trap_pc;

      case (state_reg)
         ST_BOOT: begin
            // Requests arriving in this cycle are intentionally dropped.
            redirect_valid_next = 1'b1;
            redirect_pc_next    = RESET_PC;
            pc_hold_next        = 1'b0;
            state_next          = ST_RUN;
         end

         ST_RUN: begin
            if (trap_req || br_req) begin
               if (stall) begin
                  pend_pc_next = trap_req ? trap_pc : br_pc;
                  pc_hold_next = 1'b1;
                  state_next   = ST_PEND;
               end else begin
                  issue    = 1'b1;
                  issue_pc = trap_req ? trap_pc : br_pc;
               end
            end
         end

         ST_PEND: begin
            // A late trap replaces the deferred branch; branches are ignored.
            if (trap_req) begin
               pend_pc_next = trap_pc;
            end
            if (!stall) begin
               issue    = 1'b1;
               issue_pc = trap_req ? trap_pc : pend_pc_reg;
            end else begin
               pc_hold_next = 1'b1;
            end
         end

         ST_SQUASH: begin
            // Branches here are wrong-path; only a trap can restart the window.
            if (trap_req) begin
               issue    = 1'b1;
               issue_pc = trap_pc;
            end else if (sq_cnt_reg == 2'd0) begin
               state_next = ST_RUN;
            end else begin
               sq_cnt_next = sq_cnt_reg - 2'd1;
               squash_next = 1'b1;
            end
         end

         default: begin
            state_next = ST_BOOT;
         end
      endcase

      if (issue) begin
         redirect_valid_next = 1'b1;
         redirect_pc_next    = {issue_pc[31:2], 2'b00};
         misalign_next       = (issue_pc[1:0] != 2'b00);
         pc_hold_next        = 1'b0;
         squash_next         = 1'b1;
         sq_cnt_next         = SQ_LOAD;
         state_next          = ST_SQUASH;
      end
   end

   assign redirect_valid = redirect_valid_reg;
   assign redirect_pc    = redirect_pc_reg;
   assign pc_hold        = pc_hold_reg;
   assign squash         = squash_reg;
   assign misalign       = misalign_reg;

`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] perf_redirects_reg;
   logic [31:0] perf_squashed_reg;

   // Counters follow the registered outputs, so they trail them by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_redirects_reg <= 32'h0;
         perf_squashed_reg  <= 32'h0;
      end else begin
         perf_redirects_reg <= perf_redirects_reg + {31'h0, redirect_valid_reg};
         perf_squashed_reg  <= perf_squashed_reg + {31'h0, squash_reg};
      end
   end

   assign perf_redirects = perf_redirects_reg;
   assign perf_squashed  = perf_squashed_reg;
`endif

endmodule
